fetch_stall_ctrl: RTL



---
 rtl/fetch_stall_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/fetch_stall_ctrl.sv
// Fetch-side stall/redirect controller: owns the PC and the IF/ID register.
// Optional performance counters are enabled with `define FETCH_STALL_PERF_EN.
module fetch_stall_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MAX_STALL = 15,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcEnable,
    input  logic        ifEnable,
    input  logic        controlEnable,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    input  logic        jump,
    input  logic [31:0] jumpTarget,
    input  logic [31:0] instrIn,
    output logic [31:0] pcOut,
    output logic [31:0] ifIdInstr,
    output logic [31:0] ifIdPc4,
    output logic        ifIdValid,
    output logic        idExBubble,
    output logic        stallTimeout,
    output logic [1:0]  state
`ifdef FETCH_STALL_PERF_EN
    ,
    output logic [31:0] stallCycles,
    output logic [15:0] flushCount
`endif
);

    // Handshake: the hazard unit's enables are level signals sampled every
    // rising edge; there is no valid/ready pair, every edge is a transfer.

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [7:0] MAX_STALL_C = 8'(MAX_STALL);

    state_t      stateQ;
    logic [7:0]  stallCount;
    logic [7:0]  stallCountNext;
    logic [31:0] pcPlus4;
    logic        redirect;
    logic [31:0] redirectTarget;

    assign state          = stateQ;
    assign pcPlus4        = pcOut + 32'd4;
    assign redirect       = branchTaken | jump;
    assign redirectTarget = branchTaken ? branchTarget : jumpTarget;
    assign stallCountNext = (stallCount == 8'hFF) ? stallCount : stallCount + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            pcOut        <= RESET_PC;
            ifIdInstr    <= NOP_WORD;
            ifIdPc4      <= 32'd0;
            ifIdValid    <= 1'b0;
            idExBubble   <= 1'b1;
            stallTimeout <= 1'b0;
            stateQ       <= RUN;
            stallCount   <= 8'd0;
        end else if (redirect) begin
            // Redirect beats any hold request; the wrong-path fetch is squashed.
            pcOut      <= redirectTarget;
            ifIdInstr  <= NOP_WORD;
            ifIdValid  <= 1'b0;
            idExBubble <= 1'b1;
            stateQ     <= FLUSH;
            stallCount <= 8'd0;
        end else if (!pcEnable) begin
            if (ifEnable) begin
                ifIdInstr <= instrIn;
                ifIdPc4   <= pcPlus4;
                ifIdValid <= 1'b1;
            end
            idExBubble <= ~controlEnable;
            stateQ     <= STALL;
            stallCount <= stallCountNext;
            if (stallCountNext >= MAX_STALL_C) begin
                stallTimeout <= 1'b1;
            end
        end else begin
            pcOut      <= pcPlus4;
            ifIdInstr  <= instrIn;
            ifIdPc4    <= pcPlus4;
            ifIdValid  <= 1'b1;
            idExBubble <= ~controlEnable;
            stateQ     <= RUN;
            stallCount <= 8'd0;
        end
    end

`ifdef FETCH_STALL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCycles <= 32'd0;
            flushCount  <= 16'd0;
        end else if (redirect) begin
            flushCount <= flushCount + 16'd1;
        end else if (!pcEnable) begin
            stallCycles <= stallCycles + 32'd1;
        end
    end
`endif

endmodule
